// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip select and full/empty status.
// Define FIFO_ERR_FLAGS_EN to add registered overflow/underflow pulses.
module sync_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  wr_acc, rd_acc;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign data_out = data_out_q;

    always_comb begin
        wr_acc     = cs & wr_en & ~full;
        rd_acc     = cs & rd_en & ~empty;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        data_out_d = data_out_q;
        if (rd_acc) begin
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; empty pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = cs & wr_en & full;
        underflow_d = cs & rd_en & empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed scoreboard bench for sync_fifo (depth 8, 32-bit words).
module tb_sync_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        empty;
    logic        full;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] sb[$];
    logic [31:0] exp_data = '0;

    sync_fifo #(
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .data_in (data_in),
        .data_out(data_out),
        .empty   (empty),
        .full    (full)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".data"}, data_out, exp_data);
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, sb.size() == 0});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, sb.size() == DEPTH});
    endtask

    // One clock of stimulus; the model decides acceptance from its own count.
    task automatic step(input string tag, input logic c, input logic w,
                        input logic r, input logic [31:0] d);
        logic wacc, racc, eovf, eudf;
        @(negedge clk);
        cs = c;
        wr_en = w;
        rd_en = r;
        data_in = d;
        wacc = c & w & (sb.size() < DEPTH);
        racc = c & r & (sb.size() > 0);
        eovf = c & w & (sb.size() == DEPTH);
        eudf = c & r & (sb.size() == 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (racc) exp_data = sb.pop_front();
        if (wacc) sb.push_back(d);
        chk_state(tag);
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eovf});
        chk({tag, ".udf"}, {31'd0, underflow}, {31'd0, eudf});
`else
        if (eovf || eudf) sb = sb;
`endif
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_data = '0;
        chk_state(tag);
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, ".udf"}, {31'd0, underflow}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        async_reset("reset0");

        // Basic ordering
        step("wr1", 1, 1, 0, 32'd1);
        step("wr10", 1, 1, 0, 32'd10);
        step("wr100", 1, 1, 0, 32'd100);
        for (int i = 0; i < 3; i++) step("rd_basic", 1, 0, 1, 32'd0);

        // Interleaved, wraps pointers
        for (int i = 0; i < 8; i++) begin
            step("il_wr", 1, 1, 0, 32'd1 << i);
            step("il_rd", 1, 0, 1, 32'd0);
        end

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 8; i++) step("fill", 1, 1, 0, 32'd1 << i);
        step("ovf_wr", 1, 1, 0, 32'hDEAD);
        for (int i = 0; i < 8; i++) step("drain", 1, 0, 1, 32'd0);
        step("udf_rd", 1, 0, 1, 32'd0);

        // Chip select gating
        step("cs_empty", 0, 1, 1, 32'h5555);
        step("cs_pre1", 1, 1, 0, 32'hA1);
        step("cs_pre2", 1, 1, 0, 32'hA2);
        step("cs_off", 0, 1, 1, 32'h77);
        step("cs_off2", 0, 0, 1, 32'h0);

        // Simultaneous access with 3 words held
        step("sim_pre", 1, 1, 0, 32'hA3);
        step("sim_rw", 1, 1, 1, 32'hB0);
        for (int i = 0; i < 5; i++) step("sim_fill", 1, 1, 0, 32'hC0 + i);
        step("sim_full_rw", 1, 1, 1, 32'hEE);
        step("sim_rw2", 1, 1, 1, 32'hEF);
        step("sim_rd", 1, 0, 1, 32'd0);

        // Reset mid-operation, then resume
        async_reset("reset_mid");
        step("post_wr", 1, 1, 0, 32'h1234_5678);
        step("post_rd", 1, 0, 1, 32'd0);
        step("post_rd_empty", 1, 0, 1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, synchronous first-in/first-out buffer of `FIFO_DEPTH` words of `DATA_WIDTH` bits with chip-select gating and full/empty status. It decouples a producer and a consumer that share one clock domain. It sits between any two blocks that exchange words at unequal or bursty rates.

## Interface
- `FIFO_DEPTH`, default 8: number of storage words. Must be a power of two, ≥ 2.
- `DATA_WIDTH`, default 32: word width in bits.
- `clk`  in  1: clock. All state changes on the rising edge, except reset.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `cs`  in  1: chip select. When 0, `wr_en` and `rd_en` are ignored.
- `wr_en`  in  1: write request, sampled on the rising edge.
- `rd_en`  in  1: read request, sampled on the rising edge.
- `data_in`  in  DATA_WIDTH: write data, sampled with `wr_en`.
- `data_out`  out  DATA_WIDTH: registered read data.
- `empty`  out  1: FIFO holds 0 words.
- `full`  out  1: FIFO holds `FIFO_DEPTH` words.
- `overflow`  out  1: present only with `FIFO_ERR_FLAGS_EN`; see Configuration.
- `underflow`  out  1: present only with `FIFO_ERR_FLAGS_EN`; see Configuration.

## Operation
- **Storage:** `FIFO_DEPTH` × `DATA_WIDTH` register array.
- **Pointers:** write and read pointers, each log2(`FIFO_DEPTH`)+1 bits. The MSB is a wrap bit; the lower bits index the array. Pointers wrap naturally modulo 2·`FIFO_DEPTH`.
- **Status flags:**
  - `empty` = (wr_ptr == rd_ptr).
  - `full` = (lower bits equal) and (MSBs differ).
  - Both are combinational from the pointer registers.
- **Accepted write:** `cs & wr_en & !full`.
  - Stores `data_in` at wr_ptr[lower bits] and increments wr_ptr.
- **Accepted read:** `cs & rd_en & !empty`.
  - Loads `data_out` with mem[rd_ptr[lower bits]] and increments rd_ptr.
- **Rejected write (when full):** no state change; stored data untouched.
- **Rejected read (when empty):** no state change; `data_out` holds its value.
- **Simultaneous read and write:**
  - Each is accepted independently, using the flags as they were before the edge.
  - Not empty and not full: both occur and the occupancy is unchanged.
  - Full: only the read occurs.
  - Empty: only the write occurs. There is no bypass, so `data_out` is not updated.
- **`data_out` between reads:** holds the last value read until the next accepted read.
- **Reset (`rst_n` low, any time, including mid-operation):**
  - Both pointers go to 0, so `empty`=1 and `full`=0.
  - `data_out`=0 and the error flags are 0.
  - Array contents need not be cleared.
  - Operation resumes on the first rising edge after `rst_n` is high.

## Timing
- **Write latency:** a write accepted at edge N makes `empty` deassert immediately after edge N. The word is readable by a read request sampled at edge N+1.
- **Read latency:** a read accepted at edge N drives the word on `data_out` immediately after edge N, i.e. one cycle from the request.
- **Flag updates:** `full` asserts right after the edge that accepts the `FIFO_DEPTH`-th word. It deasserts right after the next accepted read.
- **Handshake:** there is no back-pressure handshake beyond the flags. The requester must check `full`/`empty`; violating requests are dropped as above.
- **Request duration:** requests may be held high for multiple cycles; each edge is a separate request.

## Configuration
- **Macro `FIFO_ERR_FLAGS_EN` defined:**
  - Adds registered outputs `overflow` and `underflow`.
  - `overflow` pulses 1 for one cycle after an edge where `cs & wr_en & full`.
  - `underflow` pulses 1 for one cycle after an edge where `cs & rd_en & empty`.
  - Both reset to 0.
- **Macro not defined:** the ports and logic are absent. Dropped requests are silent.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle → `empty`=1, `full`=0, `data_out`=0 immediately, without waiting for a clock edge.
- **Basic order:** with `cs`=1, write 1, 10, 100 (one-cycle `wr_en` pulses), then three one-cycle reads → `data_out` = 1, 10, 100 in order; `empty`=1 after the third read.
- **Interleaved:** for i=0..7, write 2^i then read → each read returns 2^i; `empty` returns to 1 after every pair; the pointers wrap past index 7 without error.
- **Fill and drain:** write 2^0..2^7 → `full`=1 after the 8th write. A 9th write of 0xDEAD is dropped (`overflow` pulses if enabled). Eight reads return 1, 2, 4 … 128. A 9th read leaves `data_out`=128 (`underflow` pulses if enabled).
- **Chip select:** with `cs`=0, assert `wr_en`/`rd_en` → no pointer, flag or `data_out` change.
- **Simultaneous access:** with 3 words held, assert `wr_en` and `rd_en` together for one edge → oldest word out, occupancy stays 3. When full, the same request yields a read only, and `full` drops.
